// File: rtl/cpu_types_pkg.sv
// Purpose : shared CPU word types, fetch FSM states and small address helpers.
// Latency : n/a (types and functions only).
// Backpressure: n/a.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  // One buffered fetch: the instruction word plus where it came from.
  typedef struct packed {
    word_t inst;
    word_t pc;
    word_t npc;
  } fetch_entry_t;

  // Clear the byte-offset bits; masking keeps every input bit in use.
  function automatic word_t word_align(input word_t a);
    return a & ~word_t'(3);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Purpose : bundle of PC-register, instruction-memory, decode and control signals
//           around the fetch sequencer. master = sequencer side, slave = environment.
// Latency/backpressure: n/a (wiring only).
interface fetch_sequencer_if;
  import cpu_types_pkg::*;

  // PC register
  word_t pc_cur;
  logic  pc_wen;
  word_t pc_next;
  // instruction memory
  logic  iren;
  word_t iaddr;
  logic  ihit;
  word_t iload;
  // decode side
  word_t inst;
  word_t inst_pc;
  word_t inst_npc;
  logic  inst_valid;
  logic  inst_ready;
  // control
  logic  redirect;
  word_t redirect_pc;
  logic  halt;
  logic  halted;

  modport master (
    input  pc_cur, ihit, iload, inst_ready, redirect, redirect_pc, halt,
    output pc_wen, pc_next, iren, iaddr, inst, inst_pc, inst_npc, inst_valid, halted
  );

  modport slave (
    output pc_cur, ihit, iload, inst_ready, redirect, redirect_pc, halt,
    input  pc_wen, pc_next, iren, iaddr, inst, inst_pc, inst_npc, inst_valid, halted
  );

endinterface

// File: rtl/fetch_buf.sv
// Purpose : one-entry instruction/PC holding register between fetch and decode.
// Latency : load visible on o_valid/o_entry the cycle after i_load.
// Backpressure: entry held until i_consume; flush beats load beats consume.
// Ports   : i_clk/i_rst (sync, active-high), i_load+i_entry, i_consume, i_flush,
//           o_valid, o_entry.
module fetch_buf
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic         i_consume,
  input  logic         i_flush,
  input  fetch_entry_t i_entry,
  output logic         o_valid,
  output fetch_entry_t o_entry
);

  logic         r_valid;
  fetch_entry_t r_entry;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid       <= 1'b0;
      r_entry.inst  <= '0;
      r_entry.pc    <= PC_INIT;
      r_entry.npc   <= PC_INIT + 32'd4;
    end else if (i_flush) begin
      // Payload is left as-is; only the valid flag matters after a flush.
      r_valid <= 1'b0;
    end else if (i_load) begin
      // A load in the same cycle as a consume replaces the outgoing entry.
      r_valid <= 1'b1;
      r_entry <= i_entry;
    end else if (i_consume) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_entry = r_entry;

endmodule

// File: rtl/fetch_sequencer.sv
// Purpose : drives the PC register and instruction memory, buffers one fetched
//           instruction for decode, handles redirect and permanent halt.
// Latency : instruction presented one cycle after ihit; PC write same cycle.
// Backpressure: no new fetch while the buffer is full and decode is not ready.
// Ports   : CLK, RST (sync, active-high), bus (fetch_sequencer_if.master).
module fetch_sequencer
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic                  CLK,
  input  logic                  RST,
  fetch_sequencer_if.master     bus
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;

  logic         w_buf_valid;
  fetch_entry_t w_buf_entry;
  fetch_entry_t w_ld_entry;
  logic         w_free;
  logic         w_iren;
  logic         w_pc_wen;
  word_t        w_pc_next;
  word_t        w_pc_inc;
  logic         w_load;
  logic         w_flush;
  logic         w_consume;

  assign w_pc_inc   = bus.pc_cur + 32'd4;  // wraps modulo 2^32
  assign w_free     = !w_buf_valid || bus.inst_ready;
  assign w_consume  = w_buf_valid && bus.inst_ready;
  assign w_ld_entry = '{inst: bus.iload, pc: bus.pc_cur, npc: w_pc_inc};

  always_ff @(posedge CLK) begin
    if (RST) r_state <= FETCH;
    else     r_state <= w_state_nxt;
  end

  // Priority inside FETCH: halt > redirect > normal fetch. Reset gates everything.
  always_comb begin
    w_state_nxt = r_state;
    w_iren      = 1'b0;
    w_pc_wen    = 1'b0;
    w_pc_next   = w_pc_inc;
    w_load      = 1'b0;
    w_flush     = 1'b0;
    if (!RST) begin
      case (r_state)
        FETCH: begin
          if (bus.halt) begin
            w_state_nxt = HALTED;
          end else if (bus.redirect) begin
            // Any ihit this cycle is dropped; the target is fetched next cycle.
            w_pc_wen  = 1'b1;
            w_pc_next = word_align(bus.redirect_pc);
            w_flush   = 1'b1;
          end else begin
            w_iren = w_free;
            if (w_free && bus.ihit) begin
              w_pc_wen = 1'b1;
              w_load   = 1'b1;
            end
          end
        end
        HALTED: begin
          // Only reset leaves; a buffered instruction still drains via w_consume.
        end
        default: w_state_nxt = FETCH;
      endcase
    end
  end

  fetch_buf #(
    .PC_INIT (PC_INIT)
  ) u_fetch_buf (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_load    (w_load),
    .i_consume (w_consume),
    .i_flush   (w_flush),
    .i_entry   (w_ld_entry),
    .o_valid   (w_buf_valid),
    .o_entry   (w_buf_entry)
  );

  assign bus.iren       = w_iren;
  assign bus.iaddr      = word_align(bus.pc_cur);
  assign bus.pc_wen     = w_pc_wen;
  assign bus.pc_next    = w_pc_next;
  assign bus.inst       = w_buf_entry.inst;
  assign bus.inst_pc    = w_buf_entry.pc;
  assign bus.inst_npc   = w_buf_entry.npc;
  assign bus.inst_valid = w_buf_valid;
  assign bus.halted     = (r_state == HALTED);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Purpose : randomized bench for fetch_sequencer with a queue-based reference model
//           and a separate delivery monitor.
// Latency/backpressure: bench only.
module tb_fetch_sequencer;
  import cpu_types_pkg::*;

  localparam word_t PC_INIT = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_sequencer_if ifc();

  fetch_sequencer #(
    .PC_INIT (PC_INIT)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (ifc.master)
  );

  typedef struct {
    word_t inst;
    word_t pc;
    word_t npc;
  } exp_t;

  int    n_cmp = 0;
  int    n_bad = 0;

  // Reference model: the buffer is a queue of at most one expected delivery,
  // env_pc plays the PC register, m_halted is the only control state.
  exp_t  q[$];
  bit    m_halted = 1'b0;
  word_t env_pc   = PC_INIT;
  bit    flush_now = 1'b0;
  bit    prev_rst  = 1'b0;

  // Stimulus knobs for the next cycle.
  bit    s_rst, s_ihit, s_ready, s_redir, s_halt;
  word_t s_rpc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set(input bit r, input bit ih, input bit rd, input bit re, input bit h,
                     input word_t rpc);
    s_rst = r; s_ihit = ih; s_ready = rd; s_redir = re; s_halt = h; s_rpc = rpc;
  endtask

  task automatic step();
    word_t ld;
    word_t exp_next;
    bit    occ, e_iren, e_wen, accept;
    @(posedge clk);
    #1;
    flush_now       = 1'b0;
    ld              = $urandom;
    rst             = s_rst;
    ifc.pc_cur      = env_pc;
    ifc.ihit        = s_ihit;
    ifc.iload       = ld;
    ifc.inst_ready  = s_ready;
    ifc.redirect    = s_redir;
    ifc.redirect_pc = s_rpc;
    ifc.halt        = s_halt;
    #1;
    occ      = (q.size() != 0);
    e_iren   = 1'b0;
    e_wen    = 1'b0;
    accept   = 1'b0;
    exp_next = env_pc + 32'd4;
    if (!s_rst && !m_halted && !s_halt) begin
      if (s_redir) begin
        e_wen    = 1'b1;
        exp_next = s_rpc & 32'hFFFF_FFFC;
      end else begin
        e_iren = !occ || s_ready;
        accept = e_iren && s_ihit;
        e_wen  = accept;
      end
    end

    chk("iren",       32'(ifc.iren),       32'(e_iren));
    chk("pc_wen",     32'(ifc.pc_wen),     32'(e_wen));
    chk("pc_next",    ifc.pc_next,         exp_next);
    chk("iaddr",      ifc.iaddr,           env_pc & 32'hFFFF_FFFC);
    chk("inst_valid", 32'(ifc.inst_valid), 32'(occ));
    chk("halted",     32'(ifc.halted),     32'(m_halted));
    if (prev_rst) begin
      chk("rst_inst",     ifc.inst,     32'h0);
      chk("rst_inst_pc",  ifc.inst_pc,  PC_INIT);
      chk("rst_inst_npc", ifc.inst_npc, PC_INIT + 32'd4);
    end else if (occ) begin
      chk("hold_inst",    ifc.inst,     q[0].inst);
      chk("hold_inst_pc", ifc.inst_pc,  q[0].pc);
      chk("hold_inst_npc", ifc.inst_npc, q[0].npc);
    end

    if (s_rst) begin
      q.delete();
      m_halted  = 1'b0;
      env_pc    = PC_INIT;
      flush_now = 1'b1;
    end else begin
      if (!m_halted && s_halt) begin
        m_halted = 1'b1;
      end else if (!m_halted && s_redir) begin
        q.delete();
        flush_now = 1'b1;
      end else if (accept) begin
        q.push_back('{ld, env_pc, env_pc + 32'd4});
      end
      if (e_wen) env_pc = exp_next;
    end
    prev_rst = s_rst;
  endtask

  // Delivery monitor: every instruction decode takes must be the oldest expected one.
  always @(negedge clk) begin : mon
    exp_t e;
    if (ifc.inst_valid === 1'b1 && ifc.inst_ready === 1'b1 && !flush_now) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL deliver: unexpected instruction pc %h, none expected", ifc.inst_pc);
      end else begin
        e = q.pop_front();
        chk("deliver_inst",     ifc.inst,     e.inst);
        chk("deliver_inst_pc",  ifc.inst_pc,  e.pc);
        chk("deliver_inst_npc", ifc.inst_npc, e.npc);
      end
    end
  end

  initial begin
    rst = 1'b1;
    set(1, 1, 1, 0, 0, '0);
    // reset with memory claiming hits: no request, no PC write
    repeat (2) step();
    // straight-line streaming
    set(0, 1, 1, 0, 0, '0);
    repeat (8) step();
    // decode stalls three cycles, then resumes
    s_ready = 1'b0;
    repeat (3) step();
    s_ready = 1'b1;
    repeat (2) step();
    // redirect colliding with a hit
    s_redir = 1'b1; s_rpc = 32'h0000_0103;
    step();
    s_redir = 1'b0;
    repeat (3) step();
    // PC wraparound
    env_pc = 32'hFFFF_FFFC;
    repeat (3) step();
    // random traffic with redirects and occasional reset
    for (int i = 0; i < 1500; i++) begin
      set($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, 1'b0, $urandom);
      step();
    end
    // halt and redirect together while an instruction is held
    set(0, 1, 0, 0, 0, '0);
    step();
    set(0, 1, 0, 1, 1, 32'h0000_0200);
    step();
    set(0, 1, 0, 0, 0, '0);
    repeat (2) step();
    s_ready = 1'b1;
    repeat (2) step();
    for (int i = 0; i < 10; i++) begin
      set(0, $urandom_range(0, 1) == 1, 1'b1, $urandom_range(0, 1) == 1, 1'b0, $urandom);
      step();
    end
    // reset out of HALTED
    set(1, 1, 1, 0, 0, '0);
    step();
    set(0, 1, 1, 0, 0, '0);
    repeat (4) step();
    // reset in the middle of a memory stall
    s_ihit = 1'b0;
    repeat (3) step();
    s_rst = 1'b1;
    step();
    s_rst = 1'b0; s_ihit = 1'b1;
    repeat (3) step();
    // random traffic including halts
    for (int i = 0; i < 2000; i++) begin
      set($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
          $urandom_range(0, 199) == 0, $urandom);
      step();
    end
    @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
